// File: rtl/frac_clken_gen_if.sv
// Configuration/strobe bundle for frac_clken_gen: write handshake in, enable strobes and lock status out.
interface frac_clken_gen_if #(
    parameter int CHANNELS = 3,
    parameter int ACC_W    = 32
);
    logic                cfg_valid;
    logic                cfg_ready;
    logic [3:0]          cfg_chan;
    logic [ACC_W-1:0]    cfg_incr;
    logic [ACC_W-1:0]    cfg_phase;
    logic [CHANNELS-1:0] ce_out;
    logic                locked;

    modport master (
        output cfg_valid, cfg_chan, cfg_incr, cfg_phase,
        input  cfg_ready, ce_out, locked
    );

    modport slave (
        input  cfg_valid, cfg_chan, cfg_incr, cfg_phase,
        output cfg_ready, ce_out, locked
    );
endinterface

// File: rtl/frac_clken_gen.sv
// Multi-channel fractional clock-enable generator built from per-channel phase accumulators.
// Optional macro FRAC_CLKEN_GATE_EN: hold ce_out low while the lock counter is settling.
module frac_clken_gen #(
    parameter int CHANNELS    = 3,
    parameter int ACC_W       = 32,
    parameter int LOCK_CYCLES = 16
) (
    input  logic            refclk,
    input  logic            rst,
    frac_clken_gen_if.slave cfg
);
    localparam int CNT_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

    typedef enum logic {HOLD, RUN} state_t;

    state_t              state, next_state;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic                accept;
    logic                load;
    logic [CHANNELS-1:0] wr_sel;
    logic [CHANNELS-1:0] carry;
    logic [CHANNELS-1:0] ce_en;
    logic [CHANNELS-1:0] ce_p0;

    logic [ACC_W-1:0]    incr   [CHANNELS];
    logic [ACC_W-1:0]    phase  [CHANNELS];
    logic [ACC_W-1:0]    acc_p0 [CHANNELS];
    logic [ACC_W:0]      sum    [CHANNELS];

    // cfg_ready and locked are pure decodes of the registered state
    assign cfg.cfg_ready = (state == RUN);
    assign cfg.locked    = (state == RUN);
    assign cfg.ce_out    = ce_p0;

    always_ff @(posedge refclk) begin
        if (rst) begin
            state <= HOLD;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // Writes to out-of-range channels are consumed but select nothing, so load stays low
    always_comb begin
        accept     = cfg.cfg_valid && (state == RUN);
        wr_sel     = '0;
        for (int j = 0; j < CHANNELS; j++) begin
            if (accept && (cfg.cfg_chan == 4'(j))) wr_sel[j] = 1'b1;
        end
        load       = |wr_sel;
        next_state = state;
        cnt_next   = cnt;
        case (state)
            HOLD: begin
                cnt_next = cnt + 1'b1;
                if (cnt == CNT_LAST) next_state = RUN;
            end
            RUN: begin
                if (load) begin
                    next_state = HOLD;
                    cnt_next   = '0;
                end
            end
            default: next_state = HOLD;
        endcase
    end

    always_comb begin
        for (int j = 0; j < CHANNELS; j++) begin
            sum[j]   = {1'b0, acc_p0[j]} + {1'b0, incr[j]};
            carry[j] = sum[j][ACC_W];
        end
    end

`ifdef FRAC_CLKEN_GATE_EN
    // Gate on the state being entered so the first strobe coincides with locked rising
    assign ce_en = {CHANNELS{next_state == RUN}};
`else
    assign ce_en = {CHANNELS{1'b1}};
`endif

    // Stage p0: accumulator update and registered carry strobe
    always_ff @(posedge refclk) begin
        if (rst) begin
            incr   <= '{default: '0};
            phase  <= '{default: '0};
            acc_p0 <= '{default: '0};
            ce_p0  <= '0;
        end else begin
            for (int j = 0; j < CHANNELS; j++) begin
                if (wr_sel[j]) begin
                    incr[j]  <= cfg.cfg_incr;
                    phase[j] <= cfg.cfg_phase;
                end
                if (load) acc_p0[j] <= wr_sel[j] ? cfg.cfg_phase : phase[j];
                else      acc_p0[j] <= sum[j][ACC_W-1:0];
            end
            if (load) ce_p0 <= '0;
            else      ce_p0 <= carry & ce_en;
        end
    end
endmodule

// File: tb/tb_frac_clken_gen.sv
// Self-checking bench for frac_clken_gen (CHANNELS=3, ACC_W=32, LOCK_CYCLES=16) with a closed-form strobe model.
module tb_frac_clken_gen;
    localparam int CH   = 3;
    localparam int AW   = 32;
    localparam int LOCK = 16;

    logic refclk = 1'b0;
    logic rst    = 1'b1;

    frac_clken_gen_if #(.CHANNELS(CH), .ACC_W(AW)) bus ();

    frac_clken_gen #(.CHANNELS(CH), .ACC_W(AW), .LOCK_CYCLES(LOCK)) dut (
        .refclk (refclk),
        .rst    (rst),
        .cfg    (bus)
    );

    always #5 refclk = ~refclk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: programmed values and edges elapsed since the last load or reset
    logic [31:0] m_incr  [CH];
    logic [31:0] m_phase [CH];
    int unsigned m_k;

    typedef struct {
        logic [3:0]  chan;
        logic [31:0] incr;
        logic [31:0] phase;
        logic [7:0]  m_ch;  // ce_out[chan] at E+1..E+8, bit 0 = E+1
        logic [7:0]  m_c0;  // ce_out[0]    at E+1..E+8
    } vec_t;

    vec_t tbl [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Channel i strobes on edge k whenever phase + k*incr crosses a multiple of 2^32
    function automatic logic [2:0] model_ce();
        logic [2:0] r;
        longint unsigned ku, a, b;
        r  = '0;
        ku = 64'(m_k);
        if (m_k != 0) begin
            for (int i = 0; i < CH; i++) begin
                a    = 64'(m_phase[i]) + ku * 64'(m_incr[i]);
                b    = 64'(m_phase[i]) + (ku - 1) * 64'(m_incr[i]);
                r[i] = ((a >> 32) != (b >> 32));
            end
        end
`ifdef FRAC_CLKEN_GATE_EN
        if (m_k < LOCK) r = '0;
`endif
        return r;
    endfunction

    task automatic cycle();
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                m_incr[i]  = '0;
                m_phase[i] = '0;
            end
            m_k = 0;
        end else if (bus.cfg_valid && (m_k >= LOCK) && (bus.cfg_chan < 4'(CH))) begin
            m_incr[2'(bus.cfg_chan)]  = bus.cfg_incr;
            m_phase[2'(bus.cfg_chan)] = bus.cfg_phase;
            m_k = 0;
        end else if (m_k != 32'hFFFF_FFFF) begin
            m_k++;
        end
        @(posedge refclk);
        #1;
        check("ce_out", 64'(bus.ce_out), 64'(model_ce()));
        check("locked", 64'(bus.locked), 64'(m_k >= LOCK));
        check("cfg_ready", 64'(bus.cfg_ready), 64'(m_k >= LOCK));
    endtask

    task automatic wait_locked();
        for (int i = 0; i < 64 && !bus.locked; i++) cycle();
        check("lock_wait", 64'(bus.locked), 64'd1);
    endtask

    task automatic write(input logic [3:0] chan, input logic [31:0] incr, input logic [31:0] phase);
        bus.cfg_valid = 1'b1;
        bus.cfg_chan  = chan;
        bus.cfg_incr  = incr;
        bus.cfg_phase = phase;
        cycle();
        bus.cfg_valid = 1'b0;
    endtask

    initial begin
        logic [2:0] ce_now;
        bus.cfg_valid = 1'b0;
        bus.cfg_chan  = '0;
        bus.cfg_incr  = '0;
        bus.cfg_phase = '0;
        m_k = 0;
        for (int i = 0; i < CH; i++) begin
            m_incr[i]  = '0;
            m_phase[i] = '0;
        end

        tbl[0] = '{chan: 4'd0, incr: 32'h8000_0000, phase: 32'h0000_0000, m_ch: 8'b1010_1010, m_c0: 8'b1010_1010};
        tbl[1] = '{chan: 4'd1, incr: 32'h4000_0000, phase: 32'hC000_0000, m_ch: 8'b0001_0001, m_c0: 8'b1010_1010};
        tbl[2] = '{chan: 4'd2, incr: 32'h0000_0000, phase: 32'hFFFF_FFFF, m_ch: 8'b0000_0000, m_c0: 8'b1010_1010};
        tbl[3] = '{chan: 4'd2, incr: 32'hFFFF_FFFF, phase: 32'h0000_0000, m_ch: 8'b1111_1110, m_c0: 8'b1010_1010};

        // Reset state
        cycle();
        cycle();
        check("rst_ce", 64'(bus.ce_out), 64'd0);
        check("rst_locked", 64'(bus.locked), 64'd0);
        check("rst_ready", 64'(bus.cfg_ready), 64'd0);

        // Reset release: lock exactly on the 16th edge, no strobes
        rst = 1'b0;
        for (int e = 1; e <= LOCK; e++) begin
            cycle();
            check("rel_locked", 64'(bus.locked), (e == LOCK) ? 64'd1 : 64'd0);
            check("rel_ce", 64'(bus.ce_out), 64'd0);
        end

        // Directed writes from the table
        for (int r = 0; r < 4; r++) begin
            wait_locked();
            write(tbl[r].chan, tbl[r].incr, tbl[r].phase);
            check("E_locked", 64'(bus.locked), 64'd0);
            check("E_ce", 64'(bus.ce_out), 64'd0);
            for (int n = 0; n < 8; n++) begin
                cycle();
                ce_now = bus.ce_out;
`ifdef FRAC_CLKEN_GATE_EN
                check("tbl_ch", 64'(ce_now[2'(tbl[r].chan)]), 64'd0);
                check("tbl_c0", 64'(ce_now[0]), 64'd0);
`else
                check("tbl_ch", 64'(ce_now[2'(tbl[r].chan)]), 64'(tbl[r].m_ch[n]));
                check("tbl_c0", 64'(ce_now[0]), 64'(tbl[r].m_c0[n]));
`endif
            end
        end

        // Out-of-range channel: consumed in RUN, lock and cadence untouched
        wait_locked();
        write(4'd5, 32'h1234_5678, 32'h9ABC_DEF0);
        check("oor_locked", 64'(bus.locked), 64'd1);
        check("oor_ready", 64'(bus.cfg_ready), 64'd1);
        for (int n = 0; n < 6; n++) cycle();

        // Reset mid-HOLD with a pending write: configuration discarded
        write(4'd0, 32'h8000_0000, 32'h0000_0000);
        for (int n = 0; n < 3; n++) cycle();
        rst           = 1'b1;
        bus.cfg_valid = 1'b1;
        bus.cfg_chan  = 4'd1;
        bus.cfg_incr  = 32'h4000_0000;
        cycle();
        check("mid_rst_ce", 64'(bus.ce_out), 64'd0);
        rst           = 1'b0;
        bus.cfg_valid = 1'b0;
        for (int e = 1; e <= LOCK + 20; e++) begin
            cycle();
            check("mid_locked", 64'(bus.locked), (e >= LOCK) ? 64'd1 : 64'd0);
            check("mid_ce", 64'(bus.ce_out), 64'd0);
        end

        // Randomised traffic against the model
        for (int n = 0; n < 800; n++) begin
            rst           = ($urandom_range(0, 149) == 0);
            bus.cfg_valid = ($urandom_range(0, 3) == 0);
            bus.cfg_chan  = 4'($urandom_range(0, 5));
            case ($urandom_range(0, 3))
                0:       bus.cfg_incr = 32'h0;
                1:       bus.cfg_incr = 32'hFFFF_FFFF;
                2:       bus.cfg_incr = $urandom() >> $urandom_range(0, 8);
                default: bus.cfg_incr = $urandom();
            endcase
            bus.cfg_phase = $urandom();
            cycle();
        end
        rst           = 1'b0;
        bus.cfg_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
